// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM encoding and line level for the transmitter and receiver
package uart_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
   localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with combinational head and separate occupancy count
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign pop_data = mem[rd_ptr];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/uart_bits_tx.sv
// uart_bits_tx: FIFO-buffered UART transmitter, start/data(LSB first)/stop frames on a registered line
module uart_bits_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int STOP_BITS = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
   tx_state_t state, next;
   logic [TW-1:0] timer;
   logic [BW-1:0] bit_cnt;
   logic [DATA_BITS-1:0] shift, head;
   logic full, empty, pop, tick, last, tx_d;
   assign tx_ready = !full;
   uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(tx_valid && tx_ready), .push_data(tx_data),
      .pop(pop), .pop_data(head), .full(full), .empty(empty), .count(fifo_count)
   );
   assign tick = timer == TW'(CLKS_PER_BIT - 1);
   // bit_cnt counts data cells in DATA and stop cells in STOP
   assign last = state == DATA ? bit_cnt == BW'(DATA_BITS - 1) : bit_cnt == BW'(STOP_BITS - 1);
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      unique case (state)
         IDLE:  if (!empty) next = START;
         START: if (tick) next = DATA;
         DATA:  if (tick && last) next = STOP;
         STOP:  if (tick && last) next = empty ? IDLE : START;
      endcase
   end
   always_comb begin
      pop = !empty && (state == IDLE || (state == STOP && tick && last));
      tx_d = state == START ? 1'b0 : state == DATA ? shift[0] : LINE_IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         timer <= '0;
         bit_cnt <= '0;
         shift <= '0;
         tx <= LINE_IDLE;
         busy <= 1'b0;
      end else begin
         timer <= (state == IDLE || tick) ? '0 : timer + TW'(1);
         bit_cnt <= (state != next || state == IDLE) ? '0 : tick ? bit_cnt + BW'(1) : bit_cnt;
         shift <= pop ? head : (state == DATA && tick) ? shift >> 1 : shift;
         tx <= tx_d;
         busy <= state != IDLE || !empty;
      end
endmodule

// File: tb/tb_uart_bits_tx.sv
// tb_uart_bits_tx: directed vector bench for uart_bits_tx at default and slow bit rates
module tb_uart_bits_tx;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] tx_data = '0, s_data = '0;
   logic tx_valid = 1'b0, s_valid = 1'b0;
   logic tx_ready, tx, busy, s_ready, s_tx, s_busy;
   logic [2:0] fifo_count, s_count;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   uart_bits_tx dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
   );
   uart_bits_tx #(.CLKS_PER_BIT(4)) u_slow (
      .clk(clk), .reset(reset), .tx_data(s_data), .tx_valid(s_valid),
      .tx_ready(s_ready), .tx(s_tx), .busy(s_busy), .fifo_count(s_count)
   );
   typedef struct {
      logic [7:0]  d;
      logic [10:0] f;
   } vec_t;
   vec_t vt [4];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   initial begin
      logic [63:0] v, e;
      logic [10:0] sf;
      logic [7:0] w;
      logic bits_q[$];
      logic acc, ok;
      int sent, max_cnt, idx, cyc;
      vt[0] = '{8'hA5, 11'b11101001010};
      vt[1] = '{8'h3C, 11'b11001111000};
      vt[2] = '{8'hFF, 11'b11111111110};
      vt[3] = '{8'h00, 11'b11000000000};
      step(3);
      reset = 1'b0;
      step(2);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ready", tx_ready, 1);
      for (int i = 0; i < 4; i++) begin
         tx_valid = 1'b1;
         tx_data = vt[i].d;
         step;
         tx_valid = 1'b0;
         chk("vec_count_push", fifo_count, 1);
         chk("vec_busy_push", busy, 0);
         step;
         chk("vec_count_pop", fifo_count, 0);
         chk("vec_busy_pop", busy, 1);
         chk("vec_tx_pre", tx, 1);
         v = '0;
         for (int c = 0; c < 11; c++) begin
            step;
            v[c] = tx;
         end
         chk("vec_frame", v, {53'd0, vt[i].f});
         chk("vec_busy_last", busy, 1);
         step;
         chk("vec_tx_idle", tx, 1);
         chk("vec_busy_end", busy, 0);
      end
      // three words on consecutive cycles must come out as contiguous frames
      tx_valid = 1'b1;
      tx_data = 8'h3C;
      step;
      tx_data = 8'hFF;
      step;
      tx_data = 8'h00;
      v = '0;
      for (int c = 0; c < 33; c++) begin
         step;
         if (c == 0) tx_valid = 1'b0;
         v[c] = tx;
      end
      chk("loop_stream", v, {31'd0, 11'b11000000000, 11'b11111111110, 11'b11001111000});
      for (int k = 0; k < 3; k++) begin
         for (int b = 0; b < 8; b++) w[b] = v[11*k + 1 + b];
         chk("loop_word", w, k == 0 ? 8'h3C : k == 1 ? 8'hFF : 8'h00);
      end
      step;
      chk("loop_busy_end", busy, 0);
      s_valid = 1'b1;
      s_data = 8'h81;
      step;
      s_valid = 1'b0;
      step;
      chk("slow_tx_pre", s_tx, 1);
      sf = 11'b11100000010;
      v = '0;
      e = '0;
      for (int c = 0; c < 44; c++) begin
         step;
         v[c] = s_tx;
         e[c] = sf[c/4];
      end
      chk("slow_frame", v, e);
      chk("slow_busy_last", s_busy, 1);
      step;
      chk("slow_tx_idle", s_tx, 1);
      chk("slow_busy_end", s_busy, 0);
      tx_valid = 1'b1;
      tx_data = 8'h5A;
      step;
      tx_data = 8'h12;
      step;
      tx_valid = 1'b0;
      chk("pp_count_start", fifo_count, 1);
      v = '0;
      for (int c = 0; c < 33; c++) begin
         if (c == 10) begin
            chk("pp_count_pre", fifo_count, 1);
            tx_valid = 1'b1;
            tx_data = 8'h77;
         end
         step;
         if (c == 10) begin
            tx_valid = 1'b0;
            chk("pp_count_post", fifo_count, 1);
         end
         v[c] = tx;
      end
      chk("pp_stream", v, {31'd0, 11'b11011101110, 11'b11000100100, 11'b11010110100});
      step;
      chk("pp_busy_end", busy, 0);
      sent = 1;
      max_cnt = 0;
      tx_valid = 1'b1;
      tx_data = 8'd1;
      ok = 1'b1;
      for (cyc = 0; cyc < 400 && (sent <= 10 || busy); cyc++) begin
         acc = tx_valid && tx_ready;
         if (fifo_count == 3'd4 && tx_ready) ok = 1'b0;
         if (fifo_count > 3'd4) ok = 1'b0;
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         step;
         bits_q.push_back(tx);
         if (acc) begin
            if (sent == 10) tx_valid = 1'b0;
            else tx_data = 8'(sent + 1);
            sent++;
         end
      end
      chk("full_ready_rule", ok, 1);
      chk("full_max_count", max_cnt, 4);
      chk("full_sent", sent, 11);
      chk("full_drain", busy, 0);
      idx = 0;
      while (idx < bits_q.size() && bits_q[idx] == 1'b1) idx++;
      for (int k = 1; k <= 10; k++) begin
         if (idx + 10 >= bits_q.size()) begin
            chk("full_frame_present", k, 0);
            break;
         end
         for (int b = 0; b < 8; b++) w[b] = bits_q[idx + 1 + b];
         chk("full_word", {bits_q[idx], w, bits_q[idx + 9], bits_q[idx + 10]}, {1'b0, 8'(k), 2'b11});
         idx += 11;
      end
      tx_valid = 1'b1;
      tx_data = 8'h55;
      step;
      tx_data = 8'h11;
      step;
      tx_data = 8'h22;
      step;
      tx_valid = 1'b0;
      step(4);
      chk("rmf_bit3", tx, 0);
      chk("rmf_count_pre", fifo_count, 2);
      reset = 1'b1;
      #1;
      chk("rmf_tx_async", tx, 1);
      chk("rmf_count_async", fifo_count, 0);
      chk("rmf_busy_async", busy, 0);
      step(2);
      reset = 1'b0;
      ok = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step;
         if (tx !== 1'b1 || fifo_count !== 3'd0) ok = 1'b0;
      end
      chk("rmf_idle_after", ok, 1);
      chk("rmf_busy_after", busy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
